mips_regfile_sb: RTL and testbench



---
 rtl/mips_regfile_sb_if.sv | 31 +++
 rtl/mips_regfile_sb.sv | 81 ++++++++
 tb/tb_mips_regfile_sb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mips_regfile_sb_if.sv
// Register-file bus: two read ports with busy flags, one write port, one reserve port.
// The decode/writeback side uses the master modport; the register file uses the slave modport.
interface mips_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              read_busy1;
  logic              read_busy2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic              reserve_en;
  logic [ADDR_W-1:0] reserve_reg;
  logic [ADDR_W:0]   busy_count;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
           reserve_en, reserve_reg,
    input  read_data1, read_data2, read_busy1, read_busy2, busy_count
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
           reserve_en, reserve_reg,
    output read_data1, read_data2, read_busy1, read_busy2, busy_count
  );
endinterface

// File: rtl/mips_regfile_sb.sv
// Parametrised MIPS register file with per-register busy scoreboard; 0-cycle reads, 1-edge write/reserve.
// No backpressure; optional same-cycle write-to-read bypass under macro RF_BYPASS_EN.
module mips_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  mips_regfile_sb_if.slave  rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_count;

  logic              w_wr_hit;
  logic              w_rsv_hit;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   w_busy_cnt_nxt;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_bsy1;
  logic              w_bsy2;

  assign w_wr_hit  = rf.reg_write  && (rf.write_reg   != '0);
  assign w_rsv_hit = rf.reserve_en && (rf.reserve_reg != '0);

  // Reserve is applied after the write-clear so a same-edge reservation wins for the newer producer.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_hit)  w_busy_nxt[rf.write_reg]   = 1'b0;
    if (w_rsv_hit) w_busy_nxt[rf.reserve_reg] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    if (reset) w_busy_nxt = '0;
  end

  always_comb begin
    w_busy_cnt_nxt = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_regs[rf.write_reg] <= rf.write_data;
    end
    r_busy       <= w_busy_nxt;
    r_busy_count <= w_busy_cnt_nxt;
  end

  always_comb begin
    w_rd1  = (rf.read_reg1 == '0) ? '0 : r_regs[rf.read_reg1];
    w_rd2  = (rf.read_reg2 == '0) ? '0 : r_regs[rf.read_reg2];
    w_bsy1 = (rf.read_reg1 != '0) && r_busy[rf.read_reg1];
    w_bsy2 = (rf.read_reg2 != '0) && r_busy[rf.read_reg2];
`ifdef RF_BYPASS_EN
    if (!reset && w_wr_hit && (rf.read_reg1 == rf.write_reg)) begin
      w_rd1  = rf.write_data;
      w_bsy1 = w_rsv_hit && (rf.reserve_reg == rf.read_reg1);
    end
    if (!reset && w_wr_hit && (rf.read_reg2 == rf.write_reg)) begin
      w_rd2  = rf.write_data;
      w_bsy2 = w_rsv_hit && (rf.reserve_reg == rf.read_reg2);
    end
`else
    // Stored contents only; a concurrent write appears after the edge.
`endif
  end

  assign rf.read_data1 = w_rd1;
  assign rf.read_data2 = w_rd2;
  assign rf.read_busy1 = w_bsy1;
  assign rf.read_busy2 = w_bsy2;
  assign rf.busy_count = r_busy_count;
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Bench for mips_regfile_sb: directed scenarios then random traffic against an array-based model.
module tb_mips_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int N  = 8;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) rf_if ();

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] mdl_regs [N];
  bit            mdl_busy [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mdl_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mdl_busy[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int a);
    if (a == 0) return '0;
    if (BYP && !reset && rf_if.reg_write && rf_if.write_reg != 0 && int'(rf_if.write_reg) == a)
      return rf_if.write_data;
    return mdl_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
    if (BYP && !reset && rf_if.reg_write && rf_if.write_reg != 0 && int'(rf_if.write_reg) == a)
      return rf_if.reserve_en && int'(rf_if.reserve_reg) == a;
    return mdl_busy[a];
  endfunction

  task automatic step(input logic rst, input logic we, input int wa, input logic [DW-1:0] wd,
                      input logic re, input int rr, input int a1, input int a2, input bit chk_pre);
    reset             = rst;
    rf_if.reg_write   = we;
    rf_if.write_reg   = AW'(wa);
    rf_if.write_data  = wd;
    rf_if.reserve_en  = re;
    rf_if.reserve_reg = AW'(rr);
    rf_if.read_reg1   = AW'(a1);
    rf_if.read_reg2   = AW'(a2);
    #1;
    if (chk_pre) begin
      chk("rd1",   rf_if.read_data1, exp_data(a1));
      chk("rd2",   rf_if.read_data2, exp_data(a2));
      chk("bsy1",  rf_if.read_busy1, exp_busy(a1));
      chk("bsy2",  rf_if.read_busy2, exp_busy(a2));
      chk("count", rf_if.busy_count, mdl_count());
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mdl_regs[i] = '0;
        mdl_busy[i] = 1'b0;
      end
    end else begin
      if (we && wa != 0) begin
        mdl_regs[wa] = wd;
        mdl_busy[wa] = 1'b0;
      end
      if (re && rr != 0) mdl_busy[rr] = 1'b1;
    end
    @(negedge clk);
  endtask

  // Idle cycle that only reads; checks literal expectations before the edge.
  task automatic peek(input string tag, input int a1, input int a2,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                      input logic b1, input logic b2, input int cnt);
    reset            = 1'b0;
    rf_if.reg_write  = 1'b0;
    rf_if.reserve_en = 1'b0;
    rf_if.read_reg1  = AW'(a1);
    rf_if.read_reg2  = AW'(a2);
    #1;
    chk({tag, "_d1"}, rf_if.read_data1, d1);
    chk({tag, "_d2"}, rf_if.read_data2, d2);
    chk({tag, "_b1"}, rf_if.read_busy1, b1);
    chk({tag, "_b2"}, rf_if.read_busy2, b2);
    chk({tag, "_cnt"}, rf_if.busy_count, cnt);
  endtask

  initial begin
    reset = 1'b0;
    rf_if.reg_write = 1'b0; rf_if.write_reg = '0; rf_if.write_data = '0;
    rf_if.reserve_en = 1'b0; rf_if.reserve_reg = '0;
    rf_if.read_reg1 = '0; rf_if.read_reg2 = '0;
    @(negedge clk);

    // Reset then read
    step(1, 0, 0, 0, 0, 0, 1, 7, 0);
    peek("reset", 1, 7, 0, 0, 0, 0, 0);

    // Plain writes, r0 write ignored
    step(0, 1, 3, 32'hFFE7F0FF, 0, 0, 3, 0, 1);
    step(0, 1, 0, 32'h1F,       0, 0, 3, 0, 1);
    peek("wr", 3, 0, 32'hFFE7F0FF, 0, 0, 0, 0);

    // Reserve then release by write
    step(0, 0, 0, 0, 1, 5, 5, 3, 1);
    peek("rsv", 5, 3, 0, 32'hFFE7F0FF, 1, 0, 1);
    step(0, 1, 5, 32'h30F, 0, 0, 5, 1, 1);
    peek("rel", 5, 1, 32'h30F, 0, 0, 0, 0);

    // Same-edge write and reserve, then reserve of r0
    step(0, 1, 2, 32'hAB, 1, 2, 2, 5, 1);
    peek("wrrsv", 2, 5, 32'hAB, 32'h30F, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 2, 1);
    peek("rsv0", 0, 2, 0, 32'hAB, 0, 1, 1);

    // Bypass case: r4 reserved holding 0x11, then written with 0x55
    step(0, 1, 4, 32'h11, 1, 4, 4, 2, 1);
    peek("r4", 4, 2, 32'h11, 32'hAB, 1, 1, 2);
    rf_if.reg_write = 1'b1; rf_if.write_reg = 3'd4; rf_if.write_data = 32'h55;
    rf_if.read_reg1 = 3'd4; rf_if.read_reg2 = 3'd2;
    #1;
    chk("byp_d1", rf_if.read_data1, BYP ? 32'h55 : 32'h11);
    chk("byp_b1", rf_if.read_busy1, BYP ? 1'b0 : 1'b1);
    step(0, 1, 4, 32'h55, 0, 0, 4, 2, 1);
    peek("byp_post", 4, 2, 32'h55, 32'hAB, 0, 1, 1);

    // Reset drops outstanding reservations and blocks a same-cycle write
    step(0, 1, 2, 32'h77, 1, 1, 2, 1, 1);
    step(0, 0, 0, 0, 1, 6, 1, 6, 1);
    peek("two_rsv", 1, 6, 0, 0, 1, 1, 2);
    step(1, 1, 1, 32'hDEADBEEF, 1, 3, 1, 6, 1);
    peek("rst_mid", 1, 2, 0, 0, 0, 0, 0);
    peek("rst_mid_b", 3, 4, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h1234, 0, 0, 1, 6, 1);
    peek("post_rst_wr", 1, 6, 32'h1234, 0, 0, 0, 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      int wa, rr, a1, a2;
      logic rst, we, re;
      rst = ($urandom_range(0, 39) == 0);
      we  = $urandom_range(0, 1);
      re  = $urandom_range(0, 2) != 0;
      wa  = $urandom_range(0, N - 1);
      rr  = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, N - 1);
      a1  = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, N - 1);
      a2  = ($urandom_range(0, 2) == 0) ? rr : $urandom_range(0, N - 1);
      step(rst, we, wa, $urandom, re, rr, a1, a2, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
